// File: rtl/flash_ctrl_param_if.sv
// Host-side command bus of the flash controller.
// The host drives a command, address and data together with a start strobe;
// the controller returns read data, a ready flag and an error flag.
interface flash_ctrl_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 22
);
    logic [2:0]        iCMD;
    logic [ADDR_W-1:0] iADDR;
    logic [DATA_W-1:0] iDATA;
    logic              iStart;
    logic [DATA_W-1:0] oDATA;
    logic              oReady;
    logic              oErr;

    modport master (output iCMD, iADDR, iDATA, iStart, input  oDATA, oReady, oErr);
    modport slave  (input  iCMD, iADDR, iDATA, iStart, output oDATA, oReady, oErr);
endinterface

// File: rtl/flash_ctrl_param.sv
// Parallel NOR flash command controller (AMD/JEDEC unlock sequences).
// Commands run as back-to-back CLK_DIV-long bus cycles, then a completion wait.
// Optional feature macro FLASH_TOGGLE_POLL_EN: when defined the completion wait
// polls DQ6 toggle / DQ5 timeout; otherwise it is a fixed idle delay and oErr is 0.
module flash_ctrl_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 22,
    parameter int CLK_DIV  = 8,
    parameter int PRG_WAIT = 5,
    parameter int ERA_WAIT = 160000,
    parameter int CHP_WAIT = 640000,
    parameter int RST_CYC  = 2,
    parameter int POLL_MAX = 1 << 20
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    flash_ctrl_param_if.slave   host,
    inout  wire  [DATA_W-1:0]   FL_DQ,
    output logic [ADDR_W-1:0]   FL_ADDR,
    output logic                FL_CE_n,
    output logic                FL_OE_n,
    output logic                FL_WE_n,
    output logic                FL_RST_n
);
    localparam int PH_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int M1     = (CHP_WAIT > ERA_WAIT) ? CHP_WAIT : ERA_WAIT;
    localparam int M2     = (M1 > POLL_MAX) ? M1 : POLL_MAX;
    localparam int M3     = (M2 > PRG_WAIT) ? M2 : PRG_WAIT;
    localparam int M4     = (M3 > RST_CYC) ? M3 : RST_CYC;
    localparam int CNT_W  = $clog2(M4 + 1);

    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_WE_HI = PH_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYC - 1);
    // Unlock addresses are word addresses in x16 mode, byte addresses in x8 mode.
    localparam logic [ADDR_W-1:0] U1 = (DATA_W == 8) ? ADDR_W'(12'hAAA) : ADDR_W'(12'h555);
    localparam logic [ADDR_W-1:0] U2 = (DATA_W == 8) ? ADDR_W'(12'h555) : ADDR_W'(12'h2AA);

    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_BLK   = 3'd2;
    localparam logic [2:0] CMD_CHP   = 3'd4;
    localparam logic [2:0] CMD_ID    = 3'd5;
    localparam logic [2:0] CMD_RST   = 3'd6;
    localparam logic [2:0] CMD_RSV   = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_SEQ, S_RD, S_WAIT, S_RSTP, S_RREC} state_t;

    state_t            r_state, w_state_next;
    logic [2:0]        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_start_d;
    logic [PH_W-1:0]   r_phase;
    logic [2:0]        r_step;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_odata;

    logic              w_accept, w_bus_end, w_seq_last, w_wait_end;
    logic [ADDR_W-1:0] w_seq_addr;
    logic [DATA_W-1:0] w_seq_data;
    logic              w_dq_oe;
    logic [DATA_W-1:0] w_dq_out;

    assign w_accept  = (r_state == S_IDLE) && host.iStart && !r_start_d && (host.iCMD != CMD_RSV);
    assign w_bus_end = (r_phase == PH_LAST);
    assign w_seq_last = (r_cmd == CMD_WRITE) ? (r_step == 3'd3) :
                        (r_cmd == CMD_ID)    ? (r_step == 3'd2) : (r_step == 3'd5);

`ifdef FLASH_TOGGLE_POLL_EN
    logic r_dq6_prev, r_have_prev, r_err, w_poll_done, w_poll_fail;
    assign w_poll_done = r_have_prev && (FL_DQ[6] == r_dq6_prev);
    // DQ5 only counts while DQ6 still toggles; running out of reads also fails.
    assign w_poll_fail = !w_poll_done &&
                         ((r_have_prev && FL_DQ[5]) || (r_cnt >= CNT_W'(POLL_MAX - 1)));
    assign w_wait_end  = w_poll_done || w_poll_fail;
    assign host.oErr   = r_err;

    // Track the previous DQ6 sample and the sticky error of the last command.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            r_dq6_prev  <= 1'b0;
            r_have_prev <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept)
                r_err <= 1'b0;
            else if (r_state == S_WAIT && w_bus_end && w_poll_fail)
                r_err <= 1'b1;
            if (r_state != S_WAIT) begin
                r_have_prev <= 1'b0;
            end else if (w_bus_end) begin
                r_have_prev <= 1'b1;
                r_dq6_prev  <= FL_DQ[6];
            end
        end
    end
`else
    logic [CNT_W-1:0] w_wait_len;
    assign w_wait_len = (r_cmd == CMD_WRITE) ? CNT_W'(PRG_WAIT) :
                        (r_cmd == CMD_CHP)   ? CNT_W'(CHP_WAIT) : CNT_W'(ERA_WAIT);
    assign w_wait_end = (r_cnt >= w_wait_len - CNT_W'(1));
    assign host.oErr  = 1'b0;
`endif

    assign host.oReady = (r_state == S_IDLE);
    assign host.oDATA  = r_odata;
    assign FL_DQ       = w_dq_oe ? w_dq_out : {DATA_W{1'bz}};

    // Address/data of the current step of the unlock/command sequence.
    always_comb begin
        w_seq_addr = U1;
        w_seq_data = DATA_W'(8'hAA);
        case (r_step)
            3'd0: begin w_seq_addr = U1; w_seq_data = DATA_W'(8'hAA); end
            3'd1: begin w_seq_addr = U2; w_seq_data = DATA_W'(8'h55); end
            3'd2: begin
                w_seq_addr = U1;
                w_seq_data = (r_cmd == CMD_WRITE) ? DATA_W'(8'hA0) :
                             (r_cmd == CMD_ID)    ? DATA_W'(8'h90) : DATA_W'(8'h80);
            end
            3'd3: begin
                if (r_cmd == CMD_WRITE) begin
                    w_seq_addr = r_addr;
                    w_seq_data = r_data;
                end else begin
                    w_seq_addr = U1;
                    w_seq_data = DATA_W'(8'hAA);
                end
            end
            3'd4: begin w_seq_addr = U2; w_seq_data = DATA_W'(8'h55); end
            default: begin
                w_seq_addr = (r_cmd == CMD_CHP) ? U1 : r_addr;
                w_seq_data = (r_cmd == CMD_CHP) ? DATA_W'(8'h10) :
                             (r_cmd == CMD_BLK) ? DATA_W'(8'h30) : DATA_W'(8'h50);
            end
        endcase
    end

    // Next-state decode and flash pin drive; defaults are the idle pin values.
    always_comb begin
        w_state_next = r_state;
        FL_ADDR  = '0;
        FL_CE_n  = 1'b1;
        FL_OE_n  = 1'b1;
        FL_WE_n  = 1'b1;
        FL_RST_n = 1'b1;
        w_dq_oe  = 1'b0;
        w_dq_out = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (host.iCMD)
                        CMD_READ: w_state_next = S_RD;
                        CMD_RST:  w_state_next = S_RSTP;
                        default:  w_state_next = S_SEQ;
                    endcase
                end
            end
            S_SEQ: begin
                FL_CE_n  = 1'b0;
                FL_ADDR  = w_seq_addr;
                w_dq_oe  = 1'b1;
                w_dq_out = w_seq_data;
                FL_WE_n  = !((r_phase >= PH_W'(1)) && (r_phase <= PH_WE_HI));
                if (w_bus_end && w_seq_last)
                    w_state_next = (r_cmd == CMD_ID) ? S_IDLE : S_WAIT;
            end
            S_RD: begin
                FL_CE_n = 1'b0;
                FL_OE_n = 1'b0;
                FL_ADDR = r_addr;
                if (w_bus_end) w_state_next = S_IDLE;
            end
            S_WAIT: begin
`ifdef FLASH_TOGGLE_POLL_EN
                FL_CE_n = 1'b0;
                FL_OE_n = 1'b0;
                FL_ADDR = r_addr;
`endif
                if (w_bus_end && w_wait_end) w_state_next = S_IDLE;
            end
            S_RSTP: begin
                FL_RST_n = 1'b0;
                if (w_bus_end && r_cnt == RST_LAST) w_state_next = S_RREC;
            end
            S_RREC: begin
                if (w_bus_end) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, phase/step/wait counters, command latch and read result.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            r_state   <= S_IDLE;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_start_d <= host.iStart;
            r_phase   <= '0;
            r_step    <= '0;
            r_cnt     <= '0;
            r_odata   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_start_d <= host.iStart;
            if (w_accept) begin
                r_cmd  <= host.iCMD;
                r_addr <= host.iADDR;
                r_data <= host.iDATA;
            end
            if (r_state == S_IDLE || w_bus_end)
                r_phase <= '0;
            else
                r_phase <= r_phase + PH_W'(1);
            if (r_state != S_SEQ)
                r_step <= '0;
            else if (w_bus_end)
                r_step <= r_step + 3'd1;
            // Bus-cycle counter restarts on every state change and saturates.
            if (w_state_next != r_state)
                r_cnt <= '0;
            else if ((r_state == S_WAIT || r_state == S_RSTP) && w_bus_end && r_cnt != '1)
                r_cnt <= r_cnt + CNT_W'(1);
            if (r_state == S_RD && w_bus_end)
                r_odata <= FL_DQ;
        end
    end
endmodule
